// File: rtl/mem_clear_sequencer.sv
// Zero-clear sequencer: sweeps a shared clear address over the selected SRAM
// banks, then the selected L0 buffers. It queues requests that arrive during a
// sweep and pulses Done once a whole batch of requests has been cleared.
module mem_clear_sequencer #(
  parameter int Nums_SRAM_In  = 2,
  parameter int Nums_SRAM_Out = 1,
  parameter int Nums_SRAM     = Nums_SRAM_In + Nums_SRAM_Out,
  parameter int Nums_L0_In    = 2,
  parameter int Nums_L0_Out   = 1,
  parameter int Nums_L0       = Nums_L0_In + Nums_L0_Out,
  parameter int SRAM_Depth    = 16,
  parameter int L0_Depth      = 4,
  parameter int Addr_Width    = $clog2((SRAM_Depth > L0_Depth) ? SRAM_Depth : L0_Depth)
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic                  Mem_Reset,
  input  logic                  L0_Reset,
  input  logic [Nums_SRAM-1:0]  Mem_Mask,
  input  logic [Nums_L0-1:0]    L0_Mask,
  output logic [Nums_SRAM-1:0]  Mem_Clear,
  output logic [Nums_L0-1:0]    L0_Clear,
  output logic [Addr_Width-1:0] Clear_Addr,
  output logic                  Busy,
  output logic                  Datapath_Hold,
  output logic                  Done
);

  typedef enum logic [1:0] {IDLE, MEM_SWEEP, L0_SWEEP, DONE} state_t;

  localparam logic [Addr_Width-1:0] Mem_Last = Addr_Width'(SRAM_Depth - 1);
  localparam logic [Addr_Width-1:0] L0_Last  = Addr_Width'(L0_Depth - 1);

  state_t                state, state_n;
  logic [Addr_Width-1:0] addr, addr_n;
  logic [Nums_SRAM-1:0]  mem_mask_q, mem_mask_n;
  logic [Nums_L0-1:0]    l0_mask_q, l0_mask_n;
  logic                  pend_mem, pend_l0, pend_mem_n, pend_l0_n;
  logic                  enter_mem, enter_l0;

  // State, sweep address, captured masks and pending flags
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      mem_mask_q <= '0;
      l0_mask_q  <= '0;
      pend_mem   <= 1'b0;
      pend_l0    <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      mem_mask_q <= mem_mask_n;
      l0_mask_q  <= l0_mask_n;
      pend_mem   <= pend_mem_n;
      pend_l0    <= pend_l0_n;
    end
  end

  // Next state: at the end of a phase the other pending phase is preferred,
  // then a repeat of the same phase, so a batch ends with a single Done
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    mem_mask_n = mem_mask_q;
    l0_mask_n  = l0_mask_q;
    enter_mem  = 1'b0;
    enter_l0   = 1'b0;
    case (state)
      MEM_SWEEP: begin
        if (addr == Mem_Last) begin
          if (pend_l0)       enter_l0  = 1'b1;
          else if (pend_mem) enter_mem = 1'b1;
          else begin
            state_n = DONE;
            addr_n  = '0;
          end
        end else addr_n = addr + 1'b1;
      end
      L0_SWEEP: begin
        if (addr == L0_Last) begin
          if (pend_mem)     enter_mem = 1'b1;
          else if (pend_l0) enter_l0  = 1'b1;
          else begin
            state_n = DONE;
            addr_n  = '0;
          end
        end else addr_n = addr + 1'b1;
      end
      default: begin
        if (pend_mem)     enter_mem = 1'b1;
        else if (pend_l0) enter_l0  = 1'b1;
        else              state_n   = IDLE;
      end
    endcase
    if (enter_mem) begin
      state_n    = MEM_SWEEP;
      addr_n     = '0;
      mem_mask_n = Mem_Mask;
    end
    if (enter_l0) begin
      state_n   = L0_SWEEP;
      addr_n    = '0;
      l0_mask_n = L0_Mask;
    end
    // A request seen on the entry cycle re-arms the flag so the phase repeats
    pend_mem_n = Mem_Reset | (pend_mem & ~enter_mem);
    pend_l0_n  = L0_Reset  | (pend_l0  & ~enter_l0);
  end

  // Outputs decode flops only; Busy drops in the Done cycle when nothing waits
  always_comb begin
    Mem_Clear     = (state == MEM_SWEEP) ? mem_mask_q : '0;
    L0_Clear      = (state == L0_SWEEP)  ? l0_mask_q  : '0;
    Clear_Addr    = addr;
    Done          = (state == DONE);
    Busy          = (state == MEM_SWEEP) || (state == L0_SWEEP) || pend_mem || pend_l0;
    Datapath_Hold = Busy;
  end

endmodule

// File: tb/tb_mem_clear_sequencer.sv
// Bench for mem_clear_sequencer: a queue-of-beats reference model checked
// every cycle, a table of single-batch scenarios, hand-written corner cases
// and a randomized request phase.
module tb_mem_clear_sequencer;
  localparam int SD = 16;
  localparam int LD = 4;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Mem_Reset = 1'b0, L0_Reset = 1'b0;
  logic [2:0] Mem_Mask = '0, L0_Mask = '0;
  logic [2:0] Mem_Clear, L0_Clear;
  logic [3:0] Clear_Addr;
  logic       Busy, Datapath_Hold, Done;

  int total = 0, bad = 0;
  int mem_cyc = 0, l0_cyc = 0, done_cnt = 0, busy_cyc = 0;

  mem_clear_sequencer dut (
    .clk(clk), .Reset_n(Reset_n), .Mem_Reset(Mem_Reset), .L0_Reset(L0_Reset),
    .Mem_Mask(Mem_Mask), .L0_Mask(L0_Mask), .Mem_Clear(Mem_Clear),
    .L0_Clear(L0_Clear), .Clear_Addr(Clear_Addr), .Busy(Busy),
    .Datapath_Hold(Datapath_Hold), .Done(Done)
  );

  always #5 clk = ~clk;

  // Reference model: a phase entry pushes one beat per word of the memory;
  // kind 0 idle, 1 SRAM strobe, 2 L0 strobe, 3 done pulse
  typedef struct { int kind; logic [2:0] mask; int addr; } beat_t;
  beat_t q[$];
  beat_t cur;
  bit pm, pl, opm, opl;
  int want;

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q.delete();
      cur = '{0, 3'b0, 0};
      pm = 0; pl = 0;
    end else begin
      opm = pm; opl = pl;
      if (q.size() > 0) cur = q.pop_front();
      else begin
        if (cur.kind == 1)      want = opl ? 2 : (opm ? 1 : 3);
        else if (cur.kind == 2) want = opm ? 1 : (opl ? 2 : 3);
        else                    want = opm ? 1 : (opl ? 2 : 0);
        if (want == 1 || want == 2) begin
          for (int i = 0; i < (want == 1 ? SD : LD); i++)
            q.push_back('{want, (want == 1 ? Mem_Mask : L0_Mask), i});
          cur = q.pop_front();
          if (want == 1) pm = 0; else pl = 0;
        end else cur = '{want, 3'b0, 0};
      end
      pm = pm | Mem_Reset;
      pl = pl | L0_Reset;
    end
  end

  // Per-cycle comparison against the model plus batch statistics
  logic [12:0] act, exp_v;
  logic        eb;
  always @(negedge clk) begin
    eb = (cur.kind == 1 || cur.kind == 2) || pm || pl;
    exp_v = {(cur.kind == 1) ? cur.mask : 3'b0, (cur.kind == 2) ? cur.mask : 3'b0,
             (cur.kind == 1 || cur.kind == 2) ? 4'(cur.addr) : 4'd0, eb, eb, cur.kind == 3};
    act = {Mem_Clear, L0_Clear, Clear_Addr, Busy, Datapath_Hold, Done};
    total++;
    if (act !== exp_v || (Mem_Clear != 0 && L0_Clear != 0)) begin
      bad++;
      $display("FAIL cycle t=%0t got=%b want=%b", $time, act, exp_v);
    end
    if (Mem_Clear != 0) mem_cyc++;
    if (L0_Clear != 0)  l0_cyc++;
    if (Done)           done_cnt++;
    if (Busy)           busy_cyc++;
  end

  task automatic chk(input string nm, input int got, input int want_v);
    total++;
    if (got !== want_v) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want_v);
    end
  endtask

  task automatic clr_stats();
    mem_cyc = 0; l0_cyc = 0; done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic pulse(input bit mr, input bit lr, input logic [2:0] mm, input logic [2:0] lm);
    @(negedge clk);
    clr_stats();
    Mem_Reset = mr; L0_Reset = lr; Mem_Mask = mm; L0_Mask = lm;
    @(negedge clk);
    Mem_Reset = 0; L0_Reset = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((Busy || Done) && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_timeout"}, (n < 200) ? 1 : 0, 1);
  endtask

  // Wait until a given strobe kind reaches an address; sample at negedge
  task automatic wait_addr(input bit is_mem, input int a, input string nm);
    int n = 0;
    while (n < 100 && !(Clear_Addr == 4'(a) && (is_mem ? Mem_Clear != 0 : L0_Clear != 0))) begin
      @(negedge clk); n++;
    end
    chk({nm, "_reach"}, (n < 100) ? 1 : 0, 1);
  endtask

  typedef struct { bit mr; bit lr; logic [2:0] mm; logic [2:0] lm;
                   int e_mem; int e_l0; int e_done; int e_busy; } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 0, 3'b101, 3'b000, 16, 0, 1, 17};
    tbl[1] = '{1, 1, 3'b101, 3'b011, 16, 4, 1, 21};
    tbl[2] = '{0, 1, 3'b000, 3'b110, 0,  4, 1, 5};
    tbl[3] = '{1, 0, 3'b000, 3'b000, 0,  0, 1, 17};
    tbl[4] = '{1, 1, 3'b000, 3'b000, 0,  0, 1, 21};
    tbl[5] = '{1, 0, 3'b111, 3'b111, 16, 0, 1, 17};

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Mem_Reset = i[0]; L0_Reset = ~i[0]; Mem_Mask = 3'(i); L0_Mask = 3'(~i);
      chk("reset_outs", {29'd0, Mem_Clear, L0_Clear, Clear_Addr, Busy, Datapath_Hold, Done}, 0);
    end
    @(negedge clk);
    Mem_Reset = 0; L0_Reset = 0; Reset_n = 1;
    @(negedge clk);

    // Single-batch scenarios
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].mr, tbl[i].lr, tbl[i].mm, tbl[i].lm);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mem", i), mem_cyc, tbl[i].e_mem);
      chk($sformatf("vec%0d_l0", i), l0_cyc, tbl[i].e_l0);
      chk($sformatf("vec%0d_done", i), done_cnt, tbl[i].e_done);
      chk($sformatf("vec%0d_busy", i), busy_cyc, tbl[i].e_busy);
    end

    // SRAM request during the L0 sweep at address 2
    pulse(0, 1, 3'b110, 3'b011);
    wait_addr(0, 2, "l0mid");
    Mem_Reset = 1;
    @(negedge clk);
    Mem_Reset = 0;
    wait_idle("l0mid");
    chk("l0mid_mem", mem_cyc, 16);
    chk("l0mid_l0", l0_cyc, 4);
    chk("l0mid_done", done_cnt, 1);

    // SRAM re-request at SRAM address 7
    pulse(1, 0, 3'b011, 3'b000);
    wait_addr(1, 7, "rearm");
    Mem_Reset = 1;
    @(negedge clk);
    Mem_Reset = 0;
    wait_idle("rearm");
    chk("rearm_mem", mem_cyc, 32);
    chk("rearm_done", done_cnt, 1);

    // Reset dropped mid-sweep at SRAM address 5
    pulse(1, 1, 3'b111, 3'b111);
    wait_addr(1, 5, "abort");
    #2 Reset_n = 0;
    #1 chk("abort_async", {29'd0, Mem_Clear, L0_Clear, Clear_Addr, Busy, Datapath_Hold, Done}, 0);
    @(negedge clk);
    Reset_n = 1;
    clr_stats();
    repeat (6) @(negedge clk);
    chk("abort_done", done_cnt, 0);
    chk("abort_busy", busy_cyc, 0);

    // Randomized request traffic, checked by the model each cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      Mem_Reset = ($urandom_range(0, 24) == 0);
      L0_Reset  = ($urandom_range(0, 12) == 0);
      Mem_Mask  = 3'($urandom);
      L0_Mask   = 3'($urandom);
    end
    Mem_Reset = 0; L0_Reset = 0;
    @(negedge clk);
    wait_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
